// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one ALU between two requesters
// Launches one operation at a time, waits ALU_LAT cycles, returns a tagged one-cycle response.
module alu_share_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [2:0]       req0_opcode,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [2:0]       req1_opcode,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [2:0]       alu_opcode,
  output logic [WIDTH-1:0] alu_operand1,
  output logic [WIDTH-1:0] alu_operand2,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_flagc,
  input  logic             alu_flagz,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic             busy
);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             id_q, id_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [2:0]       alu_opcode_q, alu_opcode_d;
  logic [WIDTH-1:0] alu_operand1_q, alu_operand1_d;
  logic [WIDTH-1:0] alu_operand2_q, alu_operand2_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]       rsp_flags_q, rsp_flags_d;
  logic             busy_q, busy_d;

  logic grant0, grant1, accept;

  // On a tie the requester that did not win last time gets the ALU.
  assign grant0 = req0_valid & (~req1_valid | last_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_q);

  // Readies are forced low while reset is held so nothing handshakes during reset.
  assign req0_ready = rst_n & (state_q == IDLE) & grant0;
  assign req1_ready = rst_n & (state_q == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    state_d        = state_q;
    last_d         = last_q;
    id_d           = id_q;
    cnt_d          = cnt_q;
    alu_opcode_d   = alu_opcode_q;
    alu_operand1_d = alu_operand1_q;
    alu_operand2_d = alu_operand2_q;
    rsp_valid_d    = 1'b0;
    rsp_id_d       = rsp_id_q;
    rsp_result_d   = rsp_result_q;
    rsp_flags_d    = rsp_flags_q;
    busy_d         = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          alu_opcode_d   = grant1 ? req1_opcode : req0_opcode;
          alu_operand1_d = grant1 ? req1_a : req0_a;
          alu_operand2_d = grant1 ? req1_b : req0_b;
          id_d           = grant1;
          last_d         = grant1;
          cnt_d          = 3'(ALU_LAT);
          busy_d         = 1'b1;
          state_d        = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_valid_d  = 1'b1;
          rsp_id_d     = id_q;
          rsp_result_d = alu_result;
          rsp_flags_d  = {alu_overflow, alu_zero, alu_flagc, alu_flagz};
          busy_d       = 1'b0;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      last_q         <= 1'b1;
      id_q           <= 1'b0;
      cnt_q          <= 3'd0;
      alu_opcode_q   <= 3'd0;
      alu_operand1_q <= '0;
      alu_operand2_q <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_id_q       <= 1'b0;
      rsp_result_q   <= '0;
      rsp_flags_q    <= 4'd0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      last_q         <= last_d;
      id_q           <= id_d;
      cnt_q          <= cnt_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_operand1_q <= alu_operand1_d;
      alu_operand2_q <= alu_operand2_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_id_q       <= rsp_id_d;
      rsp_result_q   <= rsp_result_d;
      rsp_flags_q    <= rsp_flags_d;
      busy_q         <= busy_d;
    end
  end

  assign alu_opcode   = alu_opcode_q;
  assign alu_operand1 = alu_operand1_q;
  assign alu_operand2 = alu_operand2_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_id       = rsp_id_q;
  assign rsp_result   = rsp_result_q;
  assign rsp_flags    = rsp_flags_q;
  assign busy         = busy_q;

endmodule
